// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg
//   Shared constants and helpers for the seq_pattern waveform generator.
//   CHAR_HI / CHAR_LO : the two legal pattern characters ('-' = 1, '_' = 0).
//   MAX_CHARS         : longest pattern the helpers accept (patterns are
//                       zero-extended to this many characters).
//   dec_char(ch)      : returns {err, bit} for one pattern character.
//   pat_char(p,len,k) : returns character k (leftmost = 0) of a packed pattern.
package seq_pattern_pkg;

  localparam logic [7:0] CHAR_HI   = 8'h2D;  // '-'
  localparam logic [7:0] CHAR_LO   = 8'h5F;  // '_'
  localparam int         MAX_CHARS = 256;

  // {err, bit}: illegal characters drive the bit low and flag err.
  function automatic logic [1:0] dec_char(input logic [7:0] ch);
    logic [1:0] r;
    case (ch)
      CHAR_HI: r = 2'b01;
      CHAR_LO: r = 2'b00;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  // The leftmost character of a string literal sits in the most significant
  // byte, so char k lives in byte (len-1-k). Out-of-range k returns 0.
  function automatic logic [7:0] pat_char(input logic [8*MAX_CHARS-1:0] pattern,
                                          input int len, input int k);
    logic [7:0] c;
    c = 8'h00;
    if (k >= 0 && k < len && len <= MAX_CHARS)
      c = pattern[8*(len-1-k) +: 8];
    return c;
  endfunction

endpackage

// File: rtl/seq_pattern_char_dec.sv
// seq_pattern_char_dec
//   Combinational decoder from one ASCII pattern character to an output bit.
//   Ports:
//     ch      in  8  pattern character
//     out_bit out 1  1 for '-', 0 for '_' and for any illegal character
//     err     out 1  1 when ch is neither '-' nor '_'
module seq_pattern_char_dec
  import seq_pattern_pkg::*;
(
  input  logic [7:0] ch,
  output logic       out_bit,
  output logic       err
);

  logic [1:0] dec;

  always_comb begin
    dec     = dec_char(ch);
    err     = dec[1];
    out_bit = dec[0];
  end

endmodule

// File: rtl/seq_pattern.sv
// seq_pattern
//   Cycle-by-cycle single-bit waveform generator. Each character of PATTERN
//   sets out for one clock cycle ('-' = 1, '_' = 0), leftmost char first.
//   Optional feature macro: SEQ_PATTERN_LOOP_EN
//     defined   : after the last char the index wraps to 0 (pattern repeats)
//     undefined : the index parks on the last char until reset
//   Parameters:
//     PATTERN  ASCII string, LEN = $bits(PATTERN)/8 characters (LEN >= 1)
//     IW       width of idx; LEN must not exceed 2**IW
//   Ports:
//     clock  in  1   rising-edge clock
//     reset  in  1   synchronous active-high reset, dominates en
//     en     in  1   advance enable; 0 holds every output
//     out    out 1   decoded bit of the char at idx (registered)
//     idx    out IW  index of the char currently presented
//     done   out 1   1 while idx == LEN-1
//     err    out 1   1 while the current char is illegal
//   en is a plain advance qualifier, not a handshake: every edge with en=1
//   moves one character, with no back-pressure.
module seq_pattern
  import seq_pattern_pkg::*;
#(
  parameter     PATTERN = "-_",
  parameter int IW      = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  output logic          out,
  output logic [IW-1:0] idx,
  output logic          done,
  output logic          err
);

  localparam int LEN = $bits(PATTERN) / 8;

  generate
    if (LEN < 1) begin : g_len_min
      $error("seq_pattern: PATTERN must contain at least one character");
    end
    if (LEN > 2**IW) begin : g_len_iw
      $error("seq_pattern: PATTERN length %0d does not fit IW=%0d", LEN, IW);
    end
    if (LEN > MAX_CHARS) begin : g_len_max
      $error("seq_pattern: PATTERN length %0d exceeds %0d", LEN, MAX_CHARS);
    end
  endgenerate

  localparam logic [8*MAX_CHARS-1:0] PAT_EXT = (8*MAX_CHARS)'(PATTERN);
  localparam logic [IW-1:0]          LAST    = IW'(LEN - 1);

  logic [IW-1:0] next_idx;
  logic [IW-1:0] sel_idx;
  logic [7:0]    sel_char;
  logic          sel_bit;
  logic          sel_err;

  // Index the registers will hold after this edge. Decoding the character
  // for that index (not the current one) keeps out/done/err aligned with
  // idx on the same edge.
  always_comb begin
    next_idx = idx + IW'(1);
    if (idx == LAST) begin
`ifdef SEQ_PATTERN_LOOP_EN
      next_idx = '0;
`else
      next_idx = LAST;
`endif
    end

    sel_idx = idx;
    if (reset)   sel_idx = '0;
    else if (en) sel_idx = next_idx;

    sel_char = pat_char(PAT_EXT, LEN, int'(sel_idx));
  end

  seq_pattern_char_dec u_dec (
    .ch      (sel_char),
    .out_bit (sel_bit),
    .err     (sel_err)
  );

  // Reset loads index 0 through the same path as an advance, so the reset
  // values of out/done/err come straight from char 0.
  always_ff @(posedge clock) begin
    if (reset || en) begin
      idx  <= sel_idx;
      out  <= sel_bit;
      err  <= sel_err;
      done <= (sel_idx == LAST);
    end
  end

endmodule

// File: tb/tb_seq_pattern.sv
module tb_seq_pattern;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // One DUT per pattern under test; each has its own reset/en.
  logic       rst   [7];
  logic       en    [7];
  logic       out_s [7];
  logic [7:0] idx_s [7];
  logic       done_s[7];
  logic       err_s [7];

  int vectors     = 0;
  int miscompares = 0;

  seq_pattern #(.PATTERN("-_______-___"), .IW(8)) u0 (
    .clock(clock), .reset(rst[0]), .en(en[0]),
    .out(out_s[0]), .idx(idx_s[0]), .done(done_s[0]), .err(err_s[0]));
  seq_pattern #(.PATTERN("_--___-_"), .IW(8)) u1 (
    .clock(clock), .reset(rst[1]), .en(en[1]),
    .out(out_s[1]), .idx(idx_s[1]), .done(done_s[1]), .err(err_s[1]));
  seq_pattern #(.PATTERN("__--___-"), .IW(8)) u2 (
    .clock(clock), .reset(rst[2]), .en(en[2]),
    .out(out_s[2]), .idx(idx_s[2]), .done(done_s[2]), .err(err_s[2]));
  seq_pattern #(.PATTERN("-_-"), .IW(8)) u3 (
    .clock(clock), .reset(rst[3]), .en(en[3]),
    .out(out_s[3]), .idx(idx_s[3]), .done(done_s[3]), .err(err_s[3]));
  seq_pattern #(.PATTERN("-__"), .IW(8)) u4 (
    .clock(clock), .reset(rst[4]), .en(en[4]),
    .out(out_s[4]), .idx(idx_s[4]), .done(done_s[4]), .err(err_s[4]));
  seq_pattern #(.PATTERN("-x_"), .IW(8)) u5 (
    .clock(clock), .reset(rst[5]), .en(en[5]),
    .out(out_s[5]), .idx(idx_s[5]), .done(done_s[5]), .err(err_s[5]));
  seq_pattern #(.PATTERN("-"), .IW(8)) u6 (
    .clock(clock), .reset(rst[6]), .en(en[6]),
    .out(out_s[6]), .idx(idx_s[6]), .done(done_s[6]), .err(err_s[6]));

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int u, input string tag, input int e_idx,
                         input logic e_out, input logic e_done, input logic e_err);
    chk($sformatf("%s_idx", tag),  idx_s[u],  e_idx);
    chk($sformatf("%s_out", tag),  out_s[u],  e_out);
    chk($sformatf("%s_done", tag), done_s[u], e_done);
    chk($sformatf("%s_err", tag),  err_s[u],  e_err);
  endtask

  logic [11:0] exp0;
  logic [7:0]  exp1;
  logic [7:0]  exp2;

  initial begin
    for (int i = 0; i < 7; i++) begin
      rst[i] = 1'b1;
      en[i]  = 1'b0;
    end
    // bit k = expected out for char k
    exp0 = 12'b0001_0000_0001;  // "-_______-___"
    exp1 = 8'b0100_0110;        // "_--___-_"
    exp2 = 8'b1000_1100;        // "__--___-"
    #2;

    // Test 1: reset state, then full pass of a 12-char pattern.
    en[0] = 1'b1;
    step();
    chk_all(0, "t1_rst", 0, 1'b1, 1'b0, 1'b0);
    rst[0] = 1'b0;
    for (int k = 1; k < 12; k++) begin
      step();
      chk_all(0, $sformatf("t1_k%0d", k), k, exp0[k], k == 11, 1'b0);
    end
    step();
`ifdef SEQ_PATTERN_LOOP_EN
    chk_all(0, "t1_wrap", 0, 1'b1, 1'b0, 1'b0);
`else
    chk_all(0, "t1_park", 11, 1'b0, 1'b1, 1'b0);
`endif

    // Test 2: en toggled 1,0,1 holds idx/out for the en=0 cycle.
    en[1] = 1'b1;
    step();
    chk_all(1, "t2_rst", 0, 1'b0, 1'b0, 1'b0);
    rst[1] = 1'b0;
    step();
    chk_all(1, "t2_k1", 1, 1'b1, 1'b0, 1'b0);
    en[1] = 1'b0;
    step();
    chk_all(1, "t2_hold", 1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all(1, "t2_hold2", 1, 1'b1, 1'b0, 1'b0);
    en[1] = 1'b1;
    for (int k = 2; k < 8; k++) begin
      step();
      chk_all(1, $sformatf("t2_k%0d", k), k, exp1[k], k == 7, 1'b0);
    end

    // Test 3: reset asserted at idx 5 restarts at char 0.
    en[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    chk_all(2, "t3_at5", 5, exp2[5], 1'b0, 1'b0);
    rst[2] = 1'b1;
    step();
    chk_all(2, "t3_rst", 0, 1'b0, 1'b0, 1'b0);
    rst[2] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      chk_all(2, $sformatf("t3_k%0d", k), k, exp2[k], 1'b0, 1'b0);
    end

    // Test 4: "-_-" end-of-pattern behaviour over 10 further cycles.
    en[3] = 1'b1;
    step();
    chk_all(3, "t4_rst", 0, 1'b1, 1'b0, 1'b0);
    rst[3] = 1'b0;
    step();
    chk_all(3, "t4_k1", 1, 1'b0, 1'b0, 1'b0);
    step();
    chk_all(3, "t4_k2", 2, 1'b1, 1'b1, 1'b0);
    for (int c = 3; c < 13; c++) begin
      step();
`ifdef SEQ_PATTERN_LOOP_EN
      chk_all(3, $sformatf("t4_c%0d", c), c % 3, (c % 3) != 1, (c % 3) == 2, 1'b0);
`else
      chk_all(3, $sformatf("t4_c%0d", c), 2, 1'b1, 1'b1, 1'b0);
`endif
    end

    // Test 5: "-__" over six cycles (wraps with looping, parks without).
    en[4] = 1'b1;
    step();
    chk_all(4, "t5_c0", 0, 1'b1, 1'b0, 1'b0);
    rst[4] = 1'b0;
    for (int c = 1; c < 6; c++) begin
      step();
`ifdef SEQ_PATTERN_LOOP_EN
      chk_all(4, $sformatf("t5_c%0d", c), c % 3, (c % 3) == 0, (c % 3) == 2, 1'b0);
`else
      chk_all(4, $sformatf("t5_c%0d", c), (c < 2) ? c : 2, 1'b0, c >= 2, 1'b0);
`endif
    end

    // Test 6: illegal character flags err only at its own index.
    en[5] = 1'b1;
    step();
    chk_all(5, "t6_k0", 0, 1'b1, 1'b0, 1'b0);
    rst[5] = 1'b0;
    step();
    chk_all(5, "t6_k1", 1, 1'b0, 1'b0, 1'b1);
    step();
    chk_all(5, "t6_k2", 2, 1'b0, 1'b1, 1'b0);

    // Test 7: single-character pattern is constant with done high.
    en[6] = 1'b1;
    step();
    chk_all(6, "t7_rst", 0, 1'b1, 1'b1, 1'b0);
    rst[6] = 1'b0;
    for (int c = 1; c < 4; c++) begin
      step();
      chk_all(6, $sformatf("t7_c%0d", c), 0, 1'b1, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
